sync_fifo: RTL and testbench

Parametrised synchronous FIFO. It is the next generation of the team's 4-deep, 8-bit FIFO and generalises data width and depth. It adds an occupancy count, programmable almost-full and almost-empty thresholds, full-state push+pop throughput, and optional sticky overflow/underflow error flags. It sits between UART/peripheral producers and consumers in the same clock domain and is the drop-in buffer for all new datapaths.

---
 rtl/sync_fifo_pkg.sv | 14 +
 rtl/sync_fifo_mem.sv | 27 ++
 rtl/sync_fifo.sv | 108 ++++++++++
 tb/tb_sync_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults and width helper for sync_fifo
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 2;

  // The count register holds 0..DEPTH inclusive, so it needs one bit more than a pointer.
  localparam int COUNT_EXTRA_BITS = 1;

  function automatic int count_width(input int addr_width);
    return addr_width + COUNT_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - FIFO storage array, one synchronous write port and one asynchronous read port
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Storage is intentionally not reset; validity is tracked by the count in the parent.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parametrised first-word-fall-through FIFO; SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_THRESH  = (2**ADDR_WIDTH) - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             w_data,
  input  logic                              pop,
  output logic [DATA_WIDTH-1:0]             r_data,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic [count_width(ADDR_WIDTH)-1:0] count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                              overflow,
  output logic                              underflow
`endif
);

  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(2**ADDR_WIDTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  // Status is decoded from registered count only, so it never follows the inputs combinationally.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    if (push_ok) w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
    if (pop_ok)  r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (push & full & ~pop);
    underflow_d = underflow_q | (pop & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (push_ok),
    .waddr(w_ptr_q),
    .wdata(w_data),
    .raddr(r_ptr_q),
    .rdata(r_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo (flag checks when SYNC_FIFO_ERR_FLAGS_EN is defined)
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [7:0] w_data;
  logic       pop;
  logic [7:0] r_data;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(2),
    .AF_THRESH (3),
    .AE_THRESH (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .w_data      (w_data),
    .pop         (pop),
    .r_data      (r_data),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

`ifndef SYNC_FIFO_ERR_FLAGS_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; w_data = 8'h00;
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({count, empty, almost_empty, full, almost_full} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_status got cnt=%0d e=%b ae=%b f=%b af=%b exp cnt=0 e=1 ae=1 f=0 af=0",
               count, empty, almost_empty, full, almost_full);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got ovf=%b unf=%b exp 0 0", overflow, underflow);
    end
`endif
  endtask

  task automatic test_fill();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; w_data = vals[i];
      step();
      checks++;
      if (count !== 3'(i + 1) || r_data !== 8'h11) begin
        failures++;
        $display("FAIL fill_count_rdata[%0d] got cnt=%0d rd=%h exp cnt=%0d rd=11", i, count, r_data, i + 1);
      end
      checks++;
      if (almost_full !== (i + 1 >= 3) || full !== (i == 3) || almost_empty !== (i + 1 <= 1) || empty !== 1'b0) begin
        failures++;
        $display("FAIL fill_flags[%0d] got af=%b f=%b ae=%b e=%b exp af=%b f=%b ae=%b e=0", i,
                 almost_full, full, almost_empty, empty, (i + 1 >= 3), (i == 3), (i + 1 <= 1));
      end
    end
    push = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] drain [4];
    drain = '{8'h22, 8'h33, 8'h44, 8'h55};
    push = 1'b1; pop = 1'b1; w_data = 8'h55;
    checks++;
    if (r_data !== 8'h11) begin
      failures++;
      $display("FAIL fullpp_head_before got %h exp 11", r_data);
    end
    step();
    push = 1'b0; pop = 1'b0;
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || r_data !== 8'h22) begin
      failures++;
      $display("FAIL fullpp_after got cnt=%0d f=%b rd=%h exp cnt=4 f=1 rd=22", count, full, r_data);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (r_data !== drain[i]) begin
        failures++;
        $display("FAIL fullpp_drain[%0d] got %h exp %h", i, r_data, drain[i]);
      end
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL fullpp_drained got cnt=%0d e=%b exp cnt=0 e=1", count, empty);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [4];
    vals = '{8'ha1, 8'ha2, 8'ha3, 8'ha4};
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; w_data = vals[i];
      step();
    end
    push = 1'b1; w_data = 8'h66; pop = 1'b0;
    step();
    push = 1'b0;
    checks++;
    if (count !== 3'd4 || r_data !== 8'ha1) begin
      failures++;
      $display("FAIL ovf_dropped got cnt=%0d rd=%h exp cnt=4 rd=a1", count, r_data);
    end
    step();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b1 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_sticky got ovf=%b unf=%b exp 1 0", overflow, underflow);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (r_data !== vals[i]) begin
        failures++;
        $display("FAIL ovf_drain[%0d] got %h exp %h", i, r_data, vals[i]);
      end
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL ovf_empty got e=%b exp 1", empty);
    end
  endtask

  task automatic test_empty_push_pop();
    push = 1'b1; pop = 1'b1; w_data = 8'h77;
    step();
    push = 1'b0; pop = 1'b0;
    checks++;
    if (count !== 3'd1 || empty !== 1'b0 || r_data !== 8'h77) begin
      failures++;
      $display("FAIL emptypp got cnt=%0d e=%b rd=%h exp cnt=1 e=0 rd=77", count, empty, r_data);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++;
    if (underflow !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL emptypp_flags got unf=%b ovf=%b exp 1 1", underflow, overflow);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      push = 1'b1; w_data = 8'(8'h01 + i);
      step();
    end
    push = 1'b0;
    checks++;
    if (count !== 3'd3 || almost_full !== 1'b1) begin
      failures++;
      $display("FAIL mid_prefill got cnt=%0d af=%b exp cnt=3 af=1", count, almost_full);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got cnt=%0d e=%b ae=%b af=%b exp cnt=0 e=1 ae=1 af=0",
               count, empty, almost_empty, almost_full);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_flags got ovf=%b unf=%b exp 0 0", overflow, underflow);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_push_pop();
    test_overflow();
    test_empty_push_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
